// File: rtl/noc_flit_scoreboard.sv
// noc_flit_scoreboard: end-to-end flit scoreboard for the mesh NoC.
// Snoops local-port inject/eject handshakes and tracks per-ID bitmaps.
// It flags duplicate, unexpected and late traffic, and a sweep reports missing flits.
// Ports: clk, rst_n (async active-low); inj_fire/inj_data, ej_fire/ej_data (snoop);
//   check_start, clear (pulses); busy, done, pass, err_dup_inj, err_dup_ej,
//   err_unexp, err_late, missing_cnt, first_missing_id, max_latency.
// Optional feature macro: SB_LATENCY_EN (per-ID inject timestamps, max latency).
module noc_flit_scoreboard #(
    parameter int NUM_PORTS = 4,
    parameter int FLIT_W    = 72,
    parameter int ID_W      = 6,
    parameter int LAT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS-1:0]        inj_fire,
    input  logic [NUM_PORTS*FLIT_W-1:0] inj_data,
    input  logic [NUM_PORTS-1:0]        ej_fire,
    input  logic [NUM_PORTS*FLIT_W-1:0] ej_data,
    input  logic                        check_start,
    input  logic                        clear,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic                        err_dup_inj,
    output logic                        err_dup_ej,
    output logic                        err_unexp,
    output logic                        err_late,
    output logic [ID_W:0]               missing_cnt,
    output logic [ID_W-1:0]             first_missing_id,
    output logic [LAT_W-1:0]            max_latency
);

    localparam int NID = 1 << ID_W;

    typedef enum logic [1:0] {
        TRACK = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [NID-1:0]  r_inj_seen;
    logic [NID-1:0]  r_ej_seen;
    logic [NID-1:0]  w_inj_nxt;
    logic [NID-1:0]  w_ej_nxt;
    logic            w_dup_inj;
    logic            w_dup_ej;
    logic            w_unexp;
    logic            w_any_fire;
    logic [ID_W-1:0] w_id;

    logic [ID_W-1:0] r_idx;
    logic [ID_W:0]   r_miss;
    logic [ID_W-1:0] r_first;
    logic            r_found;
    logic            r_err_dup_inj;
    logic            r_err_dup_ej;
    logic            r_err_unexp;
    logic            r_err_late;
    logic            w_hit;
    logic            w_last;

    // Only the low ID_W bits of each flit are used as the tracked ID.
    logic w_unused_ok;
    assign w_unused_ok = ^{inj_data, ej_data};

    assign w_any_fire = |{inj_fire, ej_fire};
    assign w_hit      = r_inj_seen[r_idx] & ~r_ej_seen[r_idx];
    assign w_last     = (r_idx == {ID_W{1'b1}});

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= TRACK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (r_state)
            TRACK: begin
                if (check_start) w_state_nxt = SWEEP;
            end
            SWEEP: begin
                busy = 1'b1;
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
            end
            default: w_state_nxt = TRACK;
        endcase
        // clear overrides check_start and every other transition
        if (clear) w_state_nxt = TRACK;
    end

    // Bitmap update: ports are walked lowest first so a same-cycle
    // duplicate on a higher port sees the bit set by a lower port.
    // Unexpected uses the start-of-cycle inject map, so a same-cycle
    // inject+eject of one ID counts as unexpected.
    always_comb begin
        w_inj_nxt = r_inj_seen;
        w_ej_nxt  = r_ej_seen;
        w_dup_inj = 1'b0;
        w_dup_ej  = 1'b0;
        w_unexp   = 1'b0;
        w_id      = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (inj_fire[p]) begin
                w_id = inj_data[p*FLIT_W +: ID_W];
                if (w_inj_nxt[w_id]) w_dup_inj = 1'b1;
                w_inj_nxt[w_id] = 1'b1;
            end
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (ej_fire[p]) begin
                w_id = ej_data[p*FLIT_W +: ID_W];
                if (w_ej_nxt[w_id]) w_dup_ej = 1'b1;
                if (!r_inj_seen[w_id]) w_unexp = 1'b1;
                w_ej_nxt[w_id] = 1'b1;
            end
        end
    end

    // Bitmaps, sticky errors and sweep bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inj_seen    <= '0;
            r_ej_seen     <= '0;
            r_err_dup_inj <= 1'b0;
            r_err_dup_ej  <= 1'b0;
            r_err_unexp   <= 1'b0;
            r_err_late    <= 1'b0;
            r_idx         <= '0;
            r_miss        <= '0;
            r_first       <= '0;
            r_found       <= 1'b0;
        end else if (clear) begin
            r_inj_seen    <= '0;
            r_ej_seen     <= '0;
            r_err_dup_inj <= 1'b0;
            r_err_dup_ej  <= 1'b0;
            r_err_unexp   <= 1'b0;
            r_err_late    <= 1'b0;
            r_idx         <= '0;
            r_miss        <= '0;
            r_first       <= '0;
            r_found       <= 1'b0;
        end else begin
            unique case (r_state)
                TRACK: begin
                    r_inj_seen <= w_inj_nxt;
                    r_ej_seen  <= w_ej_nxt;
                    if (w_dup_inj) r_err_dup_inj <= 1'b1;
                    if (w_dup_ej)  r_err_dup_ej  <= 1'b1;
                    if (w_unexp)   r_err_unexp   <= 1'b1;
                    if (check_start) begin
                        r_idx   <= '0;
                        r_miss  <= '0;
                        r_first <= '0;
                        r_found <= 1'b0;
                    end
                end
                SWEEP: begin
                    if (w_any_fire) r_err_late <= 1'b1;
                    if (w_hit) begin
                        r_miss <= r_miss + 1'b1;
                        if (!r_found) begin
                            r_first <= r_idx;
                            r_found <= 1'b1;
                        end
                    end
                    r_idx <= r_idx + 1'b1;
                end
                DONE: begin
                    if (w_any_fire) r_err_late <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign err_dup_inj      = r_err_dup_inj;
    assign err_dup_ej       = r_err_dup_ej;
    assign err_unexp        = r_err_unexp;
    assign err_late         = r_err_late;
    assign missing_cnt      = r_miss;
    assign first_missing_id = r_first;
    assign pass = done & ~r_err_dup_inj & ~r_err_dup_ej & ~r_err_unexp
                & ~r_err_late & (r_miss == '0);

`ifdef SB_LATENCY_EN
    logic [LAT_W-1:0] r_cyc;
    logic [LAT_W-1:0] r_max;
    logic [LAT_W-1:0] r_stamp [NID];
    logic [LAT_W-1:0] w_lat;
    logic [LAT_W-1:0] w_lat_max;
    logic [ID_W-1:0]  w_lid;

    // Latency wraps modulo 2^LAT_W along with the free-running counter
    always_comb begin
        w_lat_max = r_max;
        w_lat     = '0;
        w_lid     = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_lid = ej_data[p*FLIT_W +: ID_W];
            if (ej_fire[p] && r_inj_seen[w_lid]) begin
                w_lat = r_cyc - r_stamp[w_lid];
                if (w_lat > w_lat_max) w_lat_max = w_lat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc <= '0;
            r_max <= '0;
        end else if (clear) begin
            r_cyc <= '0;
            r_max <= '0;
        end else begin
            r_cyc <= r_cyc + 1'b1;
            if (r_state == TRACK) r_max <= w_lat_max;
        end
    end

    // Highest port written first so the lowest port's stamp lands last
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NID; i++) r_stamp[i] <= '0;
        end else if (!clear && r_state == TRACK) begin
            for (int p = NUM_PORTS - 1; p >= 0; p--) begin
                if (inj_fire[p]) r_stamp[inj_data[p*FLIT_W +: ID_W]] <= r_cyc;
            end
        end
    end

    assign max_latency = r_max;
`else
    assign max_latency = '0;
`endif

endmodule

// File: tb/tb_noc_flit_scoreboard.sv
// tb_noc_flit_scoreboard: directed self-checking bench for noc_flit_scoreboard.
// Linear sequence of directed steps with hand-computed expectations.
module tb_noc_flit_scoreboard;

    localparam int NP = 4;
    localparam int FW = 72;
    localparam int IW = 6;
    localparam int LW = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NP-1:0]    inj_fire = '0;
    logic [NP*FW-1:0] inj_data = '0;
    logic [NP-1:0]    ej_fire = '0;
    logic [NP*FW-1:0] ej_data = '0;
    logic             check_start = 1'b0;
    logic             clear = 1'b0;
    logic             busy, done, pass;
    logic             err_dup_inj, err_dup_ej, err_unexp, err_late;
    logic [IW:0]      missing_cnt;
    logic [IW-1:0]    first_missing_id;
    logic [LW-1:0]    max_latency;

    int n_pass = 0;
    int n_tot  = 0;
    int exp_lat;
    int cyc;

    noc_flit_scoreboard #(
        .NUM_PORTS(NP), .FLIT_W(FW), .ID_W(IW), .LAT_W(LW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .inj_fire(inj_fire), .inj_data(inj_data),
        .ej_fire(ej_fire), .ej_data(ej_data),
        .check_start(check_start), .clear(clear),
        .busy(busy), .done(done), .pass(pass),
        .err_dup_inj(err_dup_inj), .err_dup_ej(err_dup_ej),
        .err_unexp(err_unexp), .err_late(err_late),
        .missing_cnt(missing_cnt), .first_missing_id(first_missing_id),
        .max_latency(max_latency)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one edge, then sample #1 later and drop the pulse inputs
    task automatic step();
        @(posedge clk);
        #1;
        inj_fire    = '0;
        ej_fire     = '0;
        check_start = 1'b0;
        clear       = 1'b0;
    endtask

    // Upper flit-number bits set to non-zero garbage; they must be ignored
    function automatic logic [FW-1:0] flit(input int id);
        logic [FW-1:0] f;
        f = '0;
        f[15:0] = 16'hA5C0 | 16'(id);
        f[FW-1:64] = 8'h3C;
        return f;
    endfunction

    task automatic set_inj(input int p, input int id);
        inj_fire[p] = 1'b1;
        inj_data[p*FW +: FW] = flit(id);
    endtask

    task automatic set_ej(input int p, input int id);
        ej_fire[p] = 1'b1;
        ej_data[p*FW +: FW] = flit(id);
    endtask

    // Check that busy lasts exactly 64 samples and done follows
    task automatic run_sweep(input string tag);
        int nb;
        int n;
        check_start = 1'b1;
        step();
        nb = 0;
        n  = 0;
        while (!done && n < 200) begin
            if (busy) nb++;
            step();
            n++;
        end
        chk({tag, "_busy_cycles"}, nb, 64);
        chk({tag, "_len"}, n, 64);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
    endtask

    initial begin
`ifdef SB_LATENCY_EN
        exp_lat = 3;
`else
        exp_lat = 0;
`endif
        #2;
        chk("rst_flags", {busy, done, pass, err_dup_inj, err_dup_ej,
                          err_unexp, err_late}, 0);
        chk("rst_missing", missing_cnt, 0);
        chk("rst_first", first_missing_id, 0);
        chk("rst_maxlat", max_latency, 0);
        #10;
        rst_n = 1'b1;
        step();

        // IDs 0..15 round-robin, each ejected 3 cycles later
        for (int c = 0; c < 19; c++) begin
            if (c < 16) set_inj(c % 4, c);
            if (c >= 3) set_ej((c - 3) % 4, c - 3);
            step();
        end
        chk("rr_errs", {err_dup_inj, err_dup_ej, err_unexp, err_late}, 0);
        run_sweep("rr");
        chk("rr_done", done, 1);
        chk("rr_missing", missing_cnt, 0);
        chk("rr_pass", pass, 1);
        chk("rr_maxlat", max_latency, exp_lat);
        step();
        chk("rr_hold", {done, pass}, 2'b11);

        // Missing flit 9
        do_clear();
        chk("clr_flags", {busy, done, pass, err_dup_inj, err_dup_ej,
                          err_unexp, err_late}, 0);
        chk("clr_missing", missing_cnt, 0);
        chk("clr_maxlat", max_latency, 0);
        set_inj(0, 5);
        step();
        set_inj(1, 9);
        step();
        set_ej(2, 5);
        step();
        run_sweep("miss");
        chk("miss_cnt", missing_cnt, 1);
        chk("miss_first", first_missing_id, 9);
        chk("miss_pass", pass, 0);

        // Duplicate inject and eject of ID 7
        do_clear();
        set_inj(0, 7);
        set_inj(2, 7);
        step();
        chk("dupinj", {err_dup_inj, err_dup_ej, err_unexp}, 3'b100);
        set_ej(3, 7);
        step();
        chk("dupej_first", err_dup_ej, 0);
        set_ej(3, 7);
        step();
        chk("dupej", {err_dup_inj, err_dup_ej, err_unexp}, 3'b110);

        // Unexpected ejects
        do_clear();
        set_ej(1, 20);
        step();
        chk("unexp20", {err_dup_inj, err_dup_ej, err_unexp}, 3'b001);
        do_clear();
        chk("unexp_clr", err_unexp, 0);
        set_inj(0, 21);
        set_ej(1, 21);
        step();
        chk("unexp21", {err_dup_inj, err_dup_ej, err_unexp}, 3'b001);

        // Late eject during sweep must not touch bitmaps
        do_clear();
        set_inj(0, 3);
        set_inj(1, 4);
        step();
        set_ej(2, 3);
        step();
        check_start = 1'b1;
        step();
        step();
        step();
        set_ej(1, 4);
        step();
        chk("late_flag", err_late, 1);
        cyc = 0;
        while (!done && cyc < 200) begin
            step();
            cyc++;
        end
        chk("late_done", done, 1);
        chk("late_missing", missing_cnt, 1);
        chk("late_first", first_missing_id, 4);
        chk("late_pass", pass, 0);
        do_clear();
        chk("late_clr_flags", {busy, done, pass, err_dup_inj, err_dup_ej,
                               err_unexp, err_late}, 0);
        chk("late_clr_missing", missing_cnt, 0);
        chk("late_clr_first", first_missing_id, 0);
        // Back in TRACK: a stray eject is unexpected, not late
        set_ej(0, 40);
        step();
        chk("late_track", {err_unexp, err_late}, 2'b10);

        // clear beats check_start
        clear = 1'b1;
        check_start = 1'b1;
        step();
        chk("clr_prio", {busy, done, err_unexp}, 0);

        // Reset mid-sweep at index 30
        set_inj(2, 10);
        step();
        check_start = 1'b1;
        step();
        for (int i = 0; i < 30; i++) step();
        chk("pre_rst", {busy, missing_cnt}, {1'b1, 7'd1});
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_missing", missing_cnt, 0);
        #2;
        rst_n = 1'b1;
        step();
        set_inj(3, 10);
        step();
        run_sweep("post_rst");
        chk("post_rst_missing", missing_cnt, 1);
        chk("post_rst_first", first_missing_id, 10);
        chk("post_rst_pass", pass, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/noc_flit_scoreboard.md
# noc_flit_scoreboard

Synthesizable end-to-end flit scoreboard for the mesh NoC, generalised to NUM_PORTS local ports and 2^ID_W tracked flit numbers. It snoops every local-port injection and ejection handshake, records per-flit-number inject/eject bitmaps, and flags duplicate, unexpected and late traffic. On request it sweeps the bitmaps and reports missing flits plus a pass/fail verdict. It sits beside the mesh in the testbed, replacing behavioural in/out arrays, and is reusable for any mesh size.

## Interface
- NUM_PORTS, 4, number of local mesh ports snooped
- FLIT_W, 72, flit width; flit number is flit[15:0]
- ID_W, 6, low bits of flit number tracked (2^ID_W entries)
- LAT_W, 16, latency counter width (used only with SB_LATENCY_EN)
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- inj_fire  in  NUM_PORTS  per port: reqin & ackin handshake completed this cycle
- inj_data  in  NUM_PORTS*FLIT_W  injected flits, port p at [p*FLIT_W +: FLIT_W]
- ej_fire  in  NUM_PORTS  per port: reqout & ackout handshake completed this cycle
- ej_data  in  NUM_PORTS*FLIT_W  ejected flits, same packing
- check_start  in  1  one-cycle pulse: begin final sweep
- clear  in  1  one-cycle pulse: wipe bitmaps/errors, return to TRACK
- busy  out  1  high in SWEEP
- done  out  1  high in DONE
- pass  out  1  done & no errors & missing_cnt==0
- err_dup_inj  out  1  sticky: ID injected twice
- err_dup_ej  out  1  sticky: ID ejected twice
- err_unexp  out  1  sticky: ID ejected without prior injection
- err_late  out  1  sticky: any fire seen outside TRACK
- missing_cnt  out  ID_W+1  count of injected-but-not-ejected IDs
- first_missing_id  out  ID_W  lowest missing ID (0 if none)
- max_latency  out  LAT_W  worst eject-minus-inject cycle count

## Operation
- ID = data[ID_W-1:0] of the firing port's flit; upper flit-number bits ignored.
- States: TRACK (after reset), SWEEP, DONE.
- TRACK: for every port with inj_fire, set inj_seen[ID]; if already set (previous cycle or lower-numbered port same cycle) set err_dup_inj. For every port with ej_fire, set ej_seen[ID]; if already set (or duplicate among ports same cycle) set err_dup_ej; if inj_seen[ID] was 0 at start of cycle set err_unexp (same-cycle inject+eject of one ID is unexpected).
- TRACK + check_start -> SWEEP; index reset to 0, missing_cnt cleared.
- SWEEP: one index per cycle; if inj_seen[idx] & ~ej_seen[idx], increment missing_cnt and latch first_missing_id if it is the first hit. After index 2^ID_W-1 -> DONE.
- Any inj_fire/ej_fire in SWEEP or DONE: bitmaps untouched, err_late set.
- DONE: outputs held until clear. clear in any state: bitmaps, errors, counters, max_latency zeroed next cycle, -> TRACK. clear beats check_start when simultaneous.
- Reset values: state TRACK, all bitmaps 0, every output 0.

## Timing
- Error flags assert the cycle after the offending fire edge.
- Sweep: check_start accepted at edge k; busy high k+1..k+2^ID_W; done high from k+2^ID_W+1. Default ID_W=6: 64 busy cycles.
- pass valid only while done=1.
- rst_n assertion mid-SWEEP aborts immediately to reset values.
- missing_cnt width ID_W+1 so all 2^ID_W IDs missing is representable.

## Configuration
- SB_LATENCY_EN defined: free-running LAT_W cycle counter (wraps); per-ID timestamp array stamped on inj_fire; on ej_fire with inj_seen set, latency = (cycle - stamp) mod 2^LAT_W; max_latency updated to the largest; lowest port wins stamp on same-cycle duplicate.
- Not defined: no counter or timestamp array; max_latency tied 0.

## Test plan
- Inject IDs 0..15 on ports round-robin, eject all 3 cycles later, check_start -> done after 65 cycles, missing_cnt=0, pass=1, max_latency=3 (with SB_LATENCY_EN).
- Inject IDs 5 and 9, eject only 5, sweep -> missing_cnt=1, first_missing_id=9, pass=0.
- Ports 0 and 2 inject ID 7 same cycle -> err_dup_inj=1 next cycle; port 3 ejects ID 7 twice -> err_dup_ej=1.
- Eject ID 20 never injected -> err_unexp=1; inject+eject ID 21 same cycle -> err_unexp=1.
- Eject during SWEEP -> err_late=1, bitmaps unchanged; clear -> all outputs 0, TRACK next cycle.
- rst_n low at sweep index 30 -> busy=0, missing_cnt=0 immediately; new sweep completes normally.
